dens_clock_monitor: RTL and testbench
=====================================

Name: dens_clock_monitor

Overview:
- Receiving end of the divided dense-layer clock: samples the slow pulse train (DIVISOR-cycle period, DIVISOR/4 high) in the fast clock domain.
- Emits a single-cycle enable strobe per slow-clock rising edge, measures period and high-width, and declares lock after consecutive conforming periods.
- Flags malformed or missing pulses so the dense-layer controller can stall instead of running on a bad enable.

Parameters:
- DIVISOR, 4, expected period in clock_in cycles (≥2).
- HIGH_CYCLES, 1, expected high-width in cycles (DIVISOR/4, min 1).
- LOCK_COUNT, 3, consecutive good periods required for lock (≥1).
- CNT_W, 28, width of the measurement counters.

Ports:
- clock_in  input  1  fast system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- div_clk_in  input  1  divided pulse train under monitor.
- clear_err  input  1  synchronous one-cycle clear of sticky error.
- strobe_out  output  1  one-cycle pulse per detected rising edge.
- period_out  output  CNT_W  last measured period, in cycles.
- high_out  output  CNT_W  last measured high-width, in cycles.
- meas_valid  output  1  one-cycle pulse when period_out/high_out update.
- locked  output  1  LOCK_COUNT consecutive good periods seen.
- error  output  1  sticky mismatch/timeout flag.

Behaviour:
- Reset (async, any time, including mid-measurement): every output 0, all counters 0, sample registers 0, FSM = IDLE.
- Sampling: d1 <= div_clk_in; d2 <= d1; rise = d1 & ~d2.
- strobe_out <= rise. Strobe is high in the 2nd cycle after div_clk_in is first sampled high. Exactly one strobe per rise, independent of FSM state.
- period_cnt: on rise, load 1; otherwise +1, saturating at 2^CNT_W-1.
- high_cnt: on rise, load 1; otherwise +1 while d1=1, else hold.
- FSM states:
  - IDLE: on rise, go to MEASURE. No measurement is latched.
  - MEASURE/TRACK, on rise: latch period_out=period_cnt and high_out=high_cnt, pulse meas_valid, then go to TRACK.
    - Good period (period_cnt==DIVISOR and high_cnt==HIGH_CYCLES): good_cnt+1, saturating at LOCK_COUNT.
    - Bad period: good_cnt=0, locked=0, error=1.
  - Timeout, in MEASURE/TRACK: if period_cnt reaches 2*DIVISOR with no rise, set error=1, locked=0, good_cnt=0, go to IDLE. Covers input stuck high or stuck low.
- locked = (good_cnt==LOCK_COUNT), registered. It asserts in the cycle after the meas_valid pulse of the LOCK_COUNT-th consecutive good period.
- Rise on the same cycle as timeout: the rise wins. Measure normally; no timeout.
- error: sticky. Cleared only by reset or clear_err.
  - If clear_err coincides with a new error condition, error stays 1.
  - clear_err does not affect locked or good_cnt.

Optional Feature:
- DENS_MON_SYNC_EN defined: a 2-flop synchronizer precedes d1, for div_clk_in from an asynchronous source. strobe_out latency rises to 4 cycles; period and width measurements are unchanged. Synchronizer flops reset to 0.
- Undefined: div_clk_in is sampled directly (same-domain source), with latency as specified above.

Test Plan:
- Drive a conforming train (DIVISOR=4, high 1 cycle), first high at cycle 10 → strobe_out at cycle 12, then every 4 cycles. First meas_valid at cycle 16 with period_out=4, high_out=1. locked=1 after 3 good periods, error=0.
- Conforming train, then one period of 5 cycles → meas_valid with period_out=5, error=1, locked=0. After 3 further good periods locked=1 again; error stays 1 until a clear_err pulse.
- Hold div_clk_in low after lock → at period_cnt=8, error=1, locked=0, FSM back to IDLE. The next rise produces a strobe but no meas_valid.
- Hold div_clk_in high for 12 cycles → a single strobe, timeout error, no further strobes until a new rise.
- Assert reset mid-period while locked → all outputs 0 immediately (asynchronously). After release, the first rise gives a strobe only; lock needs 3 fresh good periods.
- With DENS_MON_SYNC_EN defined, repeat the first scenario → strobe_out at cycle 14, same period_out=4 and high_out=1, locked after 3 periods.

Source files
------------

// File: rtl/dens_clock_monitor_if.sv
// Port bundle between the divided-clock source/consumer side and dens_clock_monitor.
// The master drives the pulse train and error clear; the slave (monitor) returns measurements and status.
interface dens_clock_monitor_if #(
    parameter int CNT_W = 28
);
    logic             div_clk_in;
    logic             clear_err;
    logic             strobe_out;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             meas_valid;
    logic             locked;
    logic             error;
    logic [1:0]       state_dbg;

    // meas_valid is a one-cycle qualifier with no ready: period_out/high_out change only
    // in the cycle meas_valid is high and hold until the next meas_valid, so the consumer
    // must capture (or simply read) them in that cycle; nothing ever waits for a consumer.
    modport master (
        output div_clk_in,
        output clear_err,
        input  strobe_out,
        input  period_out,
        input  high_out,
        input  meas_valid,
        input  locked,
        input  error,
        input  state_dbg
    );

    modport slave (
        input  div_clk_in,
        input  clear_err,
        output strobe_out,
        output period_out,
        output high_out,
        output meas_valid,
        output locked,
        output error,
        output state_dbg
    );
endinterface

// File: rtl/dens_clock_monitor.sv
// Monitors the divided dense-layer clock: rise strobe, period/high-width measurement, lock and error.
// Define DENS_MON_SYNC_EN to insert a 2-flop synchronizer ahead of the edge detector.
module dens_clock_monitor #(
    parameter int DIVISOR     = 4,
    parameter int HIGH_CYCLES = 1,
    parameter int LOCK_COUNT  = 3,
    parameter int CNT_W       = 28
) (
    input  logic              clock_in,
    input  logic              reset,
    dens_clock_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    localparam int GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIVISOR);
    localparam logic [CNT_W-1:0] HIGH_C  = CNT_W'(HIGH_CYCLES);
    localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(2 * DIVISOR);
    localparam logic [GW-1:0]    LOCK_C  = GW'(LOCK_COUNT);

    state_t           state_q, state_d;
    logic             samp_in;
    logic             d1, d2;
    logic             rise;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic [GW-1:0]    good_cnt;
    logic             latch_meas, good_period, bad_period, timeout;

    logic             strobe_q, meas_valid_q, locked_q, error_q;
    logic [CNT_W-1:0] period_q, high_q;

`ifdef DENS_MON_SYNC_EN
    // The source is asynchronous: two flops bring it into the clock_in domain first.
    logic sync1, sync2;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= mon.div_clk_in;
            sync2 <= sync1;
        end
    end

    assign samp_in = sync2;
`else
    assign samp_in = mon.div_clk_in;
`endif

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d1 <= samp_in;
            d2 <= d1;
        end
    end

    assign rise = d1 & ~d2;

    // Both counters restart at 1 on a rise, so the value seen at the next rise is the full period.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
            high_cnt   <= '0;
        end else begin
            if (rise) begin
                period_cnt <= CNT_W'(1);
            end else if (period_cnt != CNT_MAX) begin
                period_cnt <= period_cnt + 1'b1;
            end

            if (rise) begin
                high_cnt <= CNT_W'(1);
            end else if (d1 && (high_cnt != CNT_MAX)) begin
                high_cnt <= high_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A rise in the same cycle the timeout threshold is reached is measured, not timed out.
    always_comb begin
        state_d     = state_q;
        latch_meas  = 1'b0;
        good_period = 1'b0;
        bad_period  = 1'b0;
        timeout     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE, TRACK: begin
                if (rise) begin
                    latch_meas = 1'b1;
                    state_d    = TRACK;
                    if ((period_cnt == DIV_C) && (high_cnt == HIGH_C)) begin
                        good_period = 1'b1;
                    end else begin
                        bad_period = 1'b1;
                    end
                end else if (period_cnt >= TMO_C) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            strobe_q     <= 1'b0;
            meas_valid_q <= 1'b0;
            period_q     <= '0;
            high_q       <= '0;
            good_cnt     <= '0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            strobe_q     <= rise;
            meas_valid_q <= latch_meas;

            if (latch_meas) begin
                period_q <= period_cnt;
                high_q   <= high_cnt;
            end

            if (bad_period || timeout) begin
                good_cnt <= '0;
            end else if (good_period && (good_cnt != LOCK_C)) begin
                good_cnt <= good_cnt + 1'b1;
            end

            // Lock drops in the same edge as a fault but rises one cycle after the last good count.
            if (bad_period || timeout) begin
                locked_q <= 1'b0;
            end else begin
                locked_q <= (good_cnt == LOCK_C);
            end

            error_q <= bad_period | timeout | (error_q & ~mon.clear_err);
        end
    end

    assign mon.strobe_out = strobe_q;
    assign mon.meas_valid = meas_valid_q;
    assign mon.period_out = period_q;
    assign mon.high_out   = high_q;
    assign mon.locked     = locked_q;
    assign mon.error      = error_q;
    assign mon.state_dbg  = state_q;

endmodule

// File: tb/tb_dens_clock_monitor.sv
// Scoreboard bench for dens_clock_monitor: directed pulse trains with hand-computed
// strobe/measurement/status expectations, checked by an independent negedge monitor.
module tb_dens_clock_monitor;

  localparam int CNT_W = 28;
  localparam int MW    = 32 + 2 * CNT_W;
  localparam int SW    = 34;
`ifdef DENS_MON_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_rise = 0;

  // expected strobe cycles; measurement {cycle, period, high}; status {cycle, locked, error}
  logic [31:0]   exp_strobe_q[$];
  logic [MW-1:0] exp_meas_q[$];
  logic [SW-1:0] exp_stat_q[$];

  dens_clock_monitor_if #(.CNT_W(CNT_W)) mon_if ();

  dens_clock_monitor #(
    .DIVISOR(4),
    .HIGH_CYCLES(1),
    .LOCK_COUNT(3),
    .CNT_W(CNT_W)
  ) dut (
    .clock_in(clk),
    .reset(reset),
    .mon(mon_if.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected end of stimulus", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_strobe_q.size() != 0 && exp_strobe_q[0] < 32'(cyc)) begin
        check("strobe_missing", 64'(exp_strobe_q[0]), 64'(cyc));
        void'(exp_strobe_q.pop_front());
      end
      if (mon_if.strobe_out) begin
        if (exp_strobe_q.size() != 0 && exp_strobe_q[0] == 32'(cyc)) begin
          check("strobe_cycle", 64'(cyc), 64'(exp_strobe_q[0]));
          void'(exp_strobe_q.pop_front());
        end else begin
          check("strobe_unexpected", 64'(1), 64'(0));
        end
      end

      if (exp_meas_q.size() != 0 && exp_meas_q[0][MW-1 -: 32] < 32'(cyc)) begin
        check("meas_missing", 64'(exp_meas_q[0][MW-1 -: 32]), 64'(cyc));
        void'(exp_meas_q.pop_front());
      end
      if (mon_if.meas_valid) begin
        if (exp_meas_q.size() != 0 && exp_meas_q[0][MW-1 -: 32] == 32'(cyc)) begin
          check("period_out", 64'(mon_if.period_out), 64'(exp_meas_q[0][2*CNT_W-1 -: CNT_W]));
          check("high_out", 64'(mon_if.high_out), 64'(exp_meas_q[0][CNT_W-1:0]));
          void'(exp_meas_q.pop_front());
        end else begin
          check("meas_unexpected", 64'(1), 64'(0));
        end
      end

      for (int i = exp_stat_q.size() - 1; i >= 0; i--) begin
        if (exp_stat_q[i][SW-1:2] == 32'(cyc)) begin
          check("locked", 64'(mon_if.locked), 64'(exp_stat_q[i][1]));
          check("error", 64'(mon_if.error), 64'(exp_stat_q[i][0]));
          exp_stat_q.delete(i);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One slow period: hi cycles high, lo cycles low. The rise in this period strobes; if mv,
  // it also completes the previous period whose hand-computed values are ep/eh.
  // el/ee: expected locked/error one cycle after the strobe (el < 0 skips).
  task automatic pulse(input int hi, input int lo, input bit mv, input int ep, input int eh,
                       input int el, input int ee);
    @(negedge clk);
    mon_if.div_clk_in = 1'b1;
    last_rise = cyc;
    exp_strobe_q.push_back(32'(cyc + LAT));
    if (mv) exp_meas_q.push_back({32'(cyc + LAT), CNT_W'(ep), CNT_W'(eh)});
    if (el >= 0) exp_stat_q.push_back({32'(cyc + LAT + 1), el[0], ee[0]});
    repeat (hi - 1) @(negedge clk);
    @(negedge clk);
    mon_if.div_clk_in = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic expect_stat(input int at_cyc, input bit l, input bit e);
    exp_stat_q.push_back({32'(at_cyc), l, e});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobe"}, 64'(mon_if.strobe_out), 64'(0));
    check({tag, "_meas_valid"}, 64'(mon_if.meas_valid), 64'(0));
    check({tag, "_period"}, 64'(mon_if.period_out), 64'(0));
    check({tag, "_high"}, 64'(mon_if.high_out), 64'(0));
    check({tag, "_locked"}, 64'(mon_if.locked), 64'(0));
    check({tag, "_error"}, 64'(mon_if.error), 64'(0));
    check({tag, "_state"}, 64'(mon_if.state_dbg), 64'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    reset = 1'b1;
    mon_if.div_clk_in = 1'b0;
    mon_if.clear_err = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    while (cyc != 9) @(negedge clk);

    // conforming train: first high at cycle 10, strobe at 10+LAT, lock after 3 good periods
    pulse(1, 3, 0, 0, 0, -1, 0);
    pulse(1, 3, 1, 4, 1, 0, 0);
    pulse(1, 3, 1, 4, 1, 0, 0);
    pulse(1, 3, 1, 4, 1, 1, 0);

    // one 5-cycle period, then a 2-cycle-high period; both break lock, error sticks
    pulse(1, 4, 1, 4, 1, 1, 0);
    pulse(1, 3, 1, 5, 1, 0, 1);
    pulse(2, 2, 1, 4, 1, 0, 1);
    pulse(1, 3, 1, 4, 2, 0, 1);
    pulse(1, 3, 1, 4, 1, 0, 1);
    pulse(1, 3, 1, 4, 1, 0, 1);
    pulse(1, 3, 1, 4, 1, 1, 1);

    // hold low after lock: clear_err clears, timeout fires with a coincident clear_err
    s = last_rise;
    expect_stat(s + 6, 1'b1, 1'b0);
    expect_stat(s + LAT + 7, 1'b1, 1'b0);
    expect_stat(s + LAT + 8, 1'b0, 1'b1);
    @(negedge clk);
    mon_if.clear_err = 1'b1;
    @(negedge clk);
    mon_if.clear_err = 1'b0;
    while (cyc != s + LAT + 7) @(negedge clk);
    mon_if.clear_err = 1'b1;
    @(negedge clk);
    mon_if.clear_err = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_low_timeout", 64'(mon_if.state_dbg), 64'(0));

    // first rise out of IDLE: strobe only
    pulse(1, 3, 0, 0, 0, 0, 1);

    // clear error, one good period, then stuck high for 12 cycles
    fork
      begin
        @(negedge clk);
        @(negedge clk);
        mon_if.clear_err = 1'b1;
        @(negedge clk);
        mon_if.clear_err = 1'b0;
      end
    join_none
    pulse(1, 3, 1, 4, 1, 0, 0);
    s = cyc + 1;
    expect_stat(s + LAT + 7, 1'b0, 1'b0);
    expect_stat(s + LAT + 8, 1'b0, 1'b1);
    pulse(12, 4, 1, 4, 1, 0, 0);
    check("idle_after_high_timeout", 64'(mon_if.state_dbg), 64'(0));
    check("locked_after_high_timeout", 64'(mon_if.locked), 64'(0));

    // new rise from IDLE, then relock
    pulse(1, 3, 0, 0, 0, 0, 1);
    pulse(1, 3, 1, 4, 1, 0, 1);
    pulse(1, 3, 1, 4, 1, 0, 1);
    pulse(1, 3, 1, 4, 1, 1, 1);

    // asynchronous reset mid-period while locked
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // after reset: strobe only on first rise, lock needs 3 fresh good periods
    pulse(1, 3, 0, 0, 0, 0, 0);
    pulse(1, 3, 1, 4, 1, 0, 0);
    pulse(1, 3, 1, 4, 1, 0, 0);
    pulse(1, 3, 1, 4, 1, 1, 0);

    repeat (8) @(negedge clk);
    foreach (exp_strobe_q[i]) check("strobe_never_seen", 64'(0), 64'(exp_strobe_q[i]));
    foreach (exp_meas_q[i]) check("meas_never_seen", 64'(0), 64'(exp_meas_q[i][MW-1 -: 32]));
    foreach (exp_stat_q[i]) check("status_never_checked", 64'(0), 64'(exp_stat_q[i][SW-1:2]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
